// File: rtl/chronologic.sv
// chronologic: clocked zero-or-one-hot checker with pass/fail pulses, counters and popcount
// Ports: clk, rst (sync, active-high), en (check enable), vec (checked vector),
//   clr (sync clear), pass/fail (1-cycle result pulses), err_sticky (any fail seen),
//   pass_cnt/fail_cnt (saturating counts), ones (registered popcount of vec).
// Optional macro CHRONOLOGIC_FAIL_CAPTURE_EN adds a free-running cycle counter and
//   first_fail_vec/first_fail_cyc/first_fail_vld capture of the first fail after rst/clr.
module chronologic #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           vec,
    input  logic                       clr,
    output logic                       pass,
    output logic                       fail,
    output logic                       err_sticky,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    output logic [WIDTH-1:0]           first_fail_vec,
    output logic [CNT_W-1:0]           first_fail_cyc,
    output logic                       first_fail_vld,
`endif
    output logic [$clog2(WIDTH+1)-1:0] ones
);
    localparam int OW = $clog2(WIDTH+1);
    logic [OW-1:0] cnt;
    logic ok;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt = cnt + OW'(vec[i]);
        ok = cnt <= OW'(1);
    end
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    logic [CNT_W-1:0] cyc;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_sticky <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            ones       <= '0;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
            cyc            <= '0;
            first_fail_vec <= '0;
            first_fail_cyc <= '0;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            ones <= cnt;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
            cyc <= cyc + CNT_W'(1);
`endif
            if (clr) begin
                pass       <= 1'b0;
                fail       <= 1'b0;
                err_sticky <= 1'b0;
                pass_cnt   <= '0;
                fail_cnt   <= '0;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
                first_fail_vec <= '0;
                first_fail_cyc <= '0;
                first_fail_vld <= 1'b0;
`endif
            end else begin
                pass <= en && ok;
                fail <= en && !ok;
                if (en && ok && pass_cnt != '1)
                    pass_cnt <= pass_cnt + CNT_W'(1);
                if (en && !ok) begin
                    err_sticky <= 1'b1;
                    if (fail_cnt != '1)
                        fail_cnt <= fail_cnt + CNT_W'(1);
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
                    // cyc still holds the value of this sampling edge
                    if (!first_fail_vld) begin
                        first_fail_vec <= vec;
                        first_fail_cyc <= cyc;
                        first_fail_vld <= 1'b1;
                    end
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: table-driven scoreboard bench for chronologic plus a CNT_W=2 saturation run
module tb_chronologic;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr, en;
    logic [4:0] vec;
    logic pass, fail, err_sticky;
    logic [15:0] pass_cnt, fail_cnt;
    logic [2:0] ones;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    logic [4:0] ff_vec;
    logic [15:0] ff_cyc;
    logic ff_vld;
`endif

    logic s_rst, s_clr, s_en;
    logic [4:0] s_vec;
    logic s_pass, s_fail, s_sticky;
    logic [1:0] s_pcnt, s_fcnt;
    logic [2:0] s_ones;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    logic [4:0] s_ff_vec;
    logic [1:0] s_ff_cyc;
    logic s_ff_vld;
`endif

    chronologic #(.WIDTH(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .vec(vec), .clr(clr),
        .pass(pass), .fail(fail), .err_sticky(err_sticky),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
        .first_fail_vec(ff_vec), .first_fail_cyc(ff_cyc), .first_fail_vld(ff_vld),
`endif
        .ones(ones)
    );

    chronologic #(.WIDTH(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst(s_rst), .en(s_en), .vec(s_vec), .clr(s_clr),
        .pass(s_pass), .fail(s_fail), .err_sticky(s_sticky),
        .pass_cnt(s_pcnt), .fail_cnt(s_fcnt),
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
        .first_fail_vec(s_ff_vec), .first_fail_cyc(s_ff_cyc), .first_fail_vld(s_ff_vld),
`endif
        .ones(s_ones)
    );

    typedef struct {
        logic rst, clr, en;
        logic [4:0] vec;
        logic p, f, s;
        logic [15:0] pc, fc;
        logic [2:0] ones;
        logic fv;
        logic [4:0] fvec;
        logic [15:0] fcyc;
    } row_t;

    localparam logic I = 1'b1;
    localparam logic O = 1'b0;
    localparam int NROW = 16;

    row_t tbl [NROW];
    row_t sbq [$];
    row_t e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    initial begin
        rst = I; clr = O; en = O; vec = '0;
        s_rst = I; s_clr = O; s_en = O; s_vec = '0;
        //         rst clr en  vec       p  f  s  pc     fc     ones  fv fvec      fcyc
        tbl[0]  = '{I, O, O, 5'b00000, O, O, O, 16'd0, 16'd0, 3'd0, O, 5'b00000, 16'd0};
        tbl[1]  = '{I, O, O, 5'b00000, O, O, O, 16'd0, 16'd0, 3'd0, O, 5'b00000, 16'd0};
        tbl[2]  = '{O, O, O, 5'b00000, O, O, O, 16'd0, 16'd0, 3'd0, O, 5'b00000, 16'd0};
        tbl[3]  = '{O, O, I, 5'b00100, I, O, O, 16'd1, 16'd0, 3'd1, O, 5'b00000, 16'd0};
        tbl[4]  = '{O, O, I, 5'b00000, I, O, O, 16'd2, 16'd0, 3'd0, O, 5'b00000, 16'd0};
        tbl[5]  = '{O, O, I, 5'b10000, I, O, O, 16'd3, 16'd0, 3'd1, O, 5'b00000, 16'd0};
        tbl[6]  = '{O, O, I, 5'b11000, O, I, I, 16'd3, 16'd1, 3'd2, I, 5'b11000, 16'd4};
        tbl[7]  = '{O, O, I, 5'b11100, O, I, I, 16'd3, 16'd2, 3'd3, I, 5'b11000, 16'd4};
        tbl[8]  = '{O, O, O, 5'b01100, O, O, I, 16'd3, 16'd2, 3'd2, I, 5'b11000, 16'd4};
        tbl[9]  = '{O, O, O, 5'b11100, O, O, I, 16'd3, 16'd2, 3'd3, I, 5'b11000, 16'd4};
        tbl[10] = '{O, I, I, 5'b11000, O, O, O, 16'd0, 16'd0, 3'd2, O, 5'b00000, 16'd0};
        tbl[11] = '{O, O, I, 5'b01000, I, O, O, 16'd1, 16'd0, 3'd1, O, 5'b00000, 16'd0};
        tbl[12] = '{O, O, I, 5'b00011, O, I, I, 16'd1, 16'd1, 3'd2, I, 5'b00011, 16'd10};
        tbl[13] = '{O, O, I, 5'b11111, O, I, I, 16'd1, 16'd2, 3'd5, I, 5'b00011, 16'd10};
        tbl[14] = '{O, I, O, 5'b00000, O, O, O, 16'd0, 16'd0, 3'd0, O, 5'b00000, 16'd0};
        tbl[15] = '{I, I, I, 5'b11111, O, O, O, 16'd0, 16'd0, 3'd0, O, 5'b00000, 16'd0};

        for (int i = 0; i < NROW; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; clr = tbl[i].clr; en = tbl[i].en; vec = tbl[i].vec;
            sbq.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("r%0d pass", i), 32'(pass), 32'(e.p));
            chk($sformatf("r%0d fail", i), 32'(fail), 32'(e.f));
            chk($sformatf("r%0d sticky", i), 32'(err_sticky), 32'(e.s));
            chk($sformatf("r%0d pass_cnt", i), 32'(pass_cnt), 32'(e.pc));
            chk($sformatf("r%0d fail_cnt", i), 32'(fail_cnt), 32'(e.fc));
            chk($sformatf("r%0d ones", i), 32'(ones), 32'(e.ones));
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
            chk($sformatf("r%0d ff_vld", i), 32'(ff_vld), 32'(e.fv));
            chk($sformatf("r%0d ff_vec", i), 32'(ff_vec), 32'(e.fvec));
            chk($sformatf("r%0d ff_cyc", i), 32'(ff_cyc), 32'(e.fcyc));
`endif
        end

        // CNT_W=2 instance: fail counter saturates at 3, then passes saturate too
        @(negedge clk);
        rst = I;
        s_rst = I; s_en = I; s_vec = 5'b11111;
        @(posedge clk); #1;
        chk("s reset fail_cnt", 32'(s_fcnt), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            s_rst = O; s_en = I; s_vec = 5'b11111;
            @(posedge clk); #1;
            chk($sformatf("s fail%0d pulse", k), 32'({s_pass, s_fail}), 32'b01);
            chk($sformatf("s fail%0d cnt", k), 32'(s_fcnt), 32'(k < 3 ? k : 3));
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s_vec = 5'b00001;
            @(posedge clk); #1;
            chk($sformatf("s pass%0d pulse", k), 32'({s_pass, s_fail}), 32'b10);
            chk($sformatf("s pass%0d cnt", k), 32'(s_pcnt), 32'(k < 3 ? k : 3));
        end
        chk("s sticky", 32'(s_sticky), 32'd1);
        chk("s fail_cnt held", 32'(s_fcnt), 32'd3);
        @(negedge clk);
        s_rst = I; s_vec = 5'b11000;
        @(posedge clk); #1;
        chk("s midrst outs", 32'({s_pass, s_fail, s_sticky, s_pcnt, s_fcnt, s_ones}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chronologic.md
Name: chronologic

Overview:
Clocked zero-or-one-hot checker for a WIDTH-bit vector. On each rising clock edge where the enable is high, it checks that at most one bit of the vector is set; all-zero passes. It emits registered pass/fail pulses, saturating pass/fail counters, a sticky error flag and a registered popcount. It sits beside a datapath as a synthesizable protocol monitor.

Parameters:
WIDTH, 5, width of the checked vector (must be ≥ 2).
CNT_W, 16, width of the pass/fail counters (and of the cycle counter when the optional feature is enabled).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset: synchronous, active-high.
en  input  1  check enable; the check applies only when this is high.
vec  input  WIDTH  vector under check.
clr  input  1  synchronous clear of counters, sticky flag and capture registers.
pass  output  1  one-cycle pulse: the check was enabled and vec was zero- or one-hot.
fail  output  1  one-cycle pulse: the check was enabled and vec had ≥ 2 bits set.
err_sticky  output  1  set by any fail; cleared only by rst or clr.
pass_cnt  output  CNT_W  saturating count of passes.
fail_cnt  output  CNT_W  saturating count of fails.
ones  output  $clog2(WIDTH+1)  registered popcount of vec, updated every cycle regardless of en.

Behaviour:
- All state updates on the rising edge of clk.
- Reset (rst=1 at an edge): pass=0, fail=0, err_sticky=0, pass_cnt=0, fail_cnt=0, ones=0. Optional capture registers are also cleared.
- rst has priority over clr; clr has priority over a check event.
- Check: ok = (popcount(vec) ≤ 1). vec=0 counts as ok.
- Latency is 1 cycle. The en/vec values sampled at edge N drive pass/fail on the outputs after edge N, for exactly one cycle.
- en=1 and ok: pass=1, fail=0, pass_cnt += 1.
- en=1 and !ok: pass=0, fail=1, fail_cnt += 1, err_sticky=1.
- en=0: pass=0, fail=0, counters unchanged. This is a vacuous cycle and is not counted.
- Counters saturate at 2^CNT_W−1 and never wrap.
- clr=1 (rst=0): counters=0, err_sticky=0, pass=0, fail=0. A check event in the same cycle is discarded; ones still updates.
- pass and fail are never both 1.
- Back-to-back enabled cycles each produce their own pulse, with no gaps required.
- vec is treated as 2-state. No X/Z handling in RTL.

Optional Feature:
Macro CHRONOLOGIC_FAIL_CAPTURE_EN.
- When defined, the block adds:
  - a free-running CNT_W cycle counter cyc, which wraps, is 0 at reset and increments every non-reset cycle;
  - output first_fail_vec (WIDTH bits);
  - output first_fail_cyc (CNT_W bits);
  - output first_fail_vld (1 bit).
- On the first fail after reset/clr, the block captures vec and the cyc value of the sampling edge, and sets first_fail_vld=1.
- Later fails do not overwrite the capture. rst/clr zero all three outputs.
- When the macro is undefined, these ports and registers do not exist.

Test Plan:
1. rst=1 for 2 cycles, then en=0, vec=5'b00000 → all outputs 0, counters 0.
2. en=1 with vec=00100, 00000 and 10000 on consecutive edges → pass=1 on each of 3 consecutive cycles; pass_cnt=3, fail_cnt=0, ones=1,0,1.
3. en=1 with vec=11000, then 11100 → fail pulses; fail_cnt=2, err_sticky=1, ones=2 then 3. With the feature: first_fail_vec=11000, first_fail_vld=1.
4. en=0 with vec=01100 or 11100 → pass=fail=0, counters unchanged, ones=2/3.
5. clr=1 together with en=1, vec=11000 → counters=0, err_sticky=0, no pulse. Next cycle en=1, vec=01000 → pass=1, pass_cnt=1.
6. CNT_W=2: apply 5 enabled fails → fail_cnt stays at 3. Then assert rst mid-stream → all zero next cycle.
